// File: rtl/multicycle_controller_if.sv
// -----------------------------------------------------------------------------
// multicycle_controller_if
// Bundles the instruction fields, ALU flags and memory handshake going into
// the multicycle controller together with every control output it drives
// back into the datapath.
//   master : the controller (reads instruction/flags/MemReady, drives controls)
//   slave  : the datapath side (drives instruction/flags/MemReady, reads controls)
// -----------------------------------------------------------------------------
interface multicycle_controller_if;
    // Latched instruction fields and datapath status
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic       MemReady;

    // Datapath enables and selects
    logic       PCWrite;
    logic       IRWrite;
    logic       MemWrite;
    logic       RegWrite;
    logic       AdrSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic [1:0] ImmSrc;
    logic [1:0] RegSrc;
    logic [1:0] ALUControl;

    // Architectural flags and debug state
    logic [3:0] Flags;
    logic [3:0] State;

    modport master (
        input  Op, Funct, Rd, Cond, ALUFlags, MemReady,
        output PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA,
        output ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl,
        output Flags, State
    );

    modport slave (
        output Op, Funct, Rd, Cond, ALUFlags, MemReady,
        input  PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA,
        input  ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl,
        input  Flags, State
    );
endinterface

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
// Control FSM for a small ARM-like multicycle datapath. Sequences fetch,
// decode, memory, data-processing and branch steps, decodes the ALU
// operation, holds the NZCV flag register and evaluates the condition field.
//
// Ports
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : multicycle_controller_if.master
//              in : Op, Funct, Rd, Cond, ALUFlags, MemReady
//              out: PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA,
//                   ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, Flags, State
//
// The datapath controls are combinational in the current state, the
// instruction fields, MemReady and the flag register, so that a memory
// handshake can complete in the same cycle it is signalled. Every write
// enable is additionally gated by reset_n so an asserted reset kills any
// in-flight write before the next clock edge.
// -----------------------------------------------------------------------------
module multicycle_controller (
    input  logic                         clk,
    input  logic                         reset_n,
    multicycle_controller_if.master      bus
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } stateType;

    stateType   curState;
    logic [3:0] flagsReg;
    logic       condEx;

    logic [1:0] aluOp;
    logic       aluNoWrite;
    logic       aluArith;
    logic       aluIsCmp;

    logic       pcWriteRaw;
    logic       irWriteRaw;
    logic       memWriteRaw;
    logic       regWriteRaw;
    logic       aluWbWrite;
    logic       adrSrc;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] resultSrc;
    logic [1:0] aluControl;

    // ARM condition evaluation on an NZCV nibble; 1111 never executes.
    function automatic logic condCheck(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n;
        logic z;
        logic c;
        logic v;
        logic result;
        n = nzcv[3];
        z = nzcv[2];
        c = nzcv[1];
        v = nzcv[0];
        case (cond)
            4'b0000: result = z;
            4'b0001: result = ~z;
            4'b0010: result = c;
            4'b0011: result = ~c;
            4'b0100: result = n;
            4'b0101: result = ~n;
            4'b0110: result = v;
            4'b0111: result = ~v;
            4'b1000: result = c & ~z;
            4'b1001: result = ~c | z;
            4'b1010: result = (n == v);
            4'b1011: result = (n != v);
            4'b1100: result = ~z & (n == v);
            4'b1101: result = z | (n != v);
            4'b1110: result = 1'b1;
            default: result = 1'b0;
        endcase
        return result;
    endfunction

    // Condition check always uses the architectural flag register.
    always_comb begin
        condEx = condCheck(bus.Cond, flagsReg);
    end

    // Data-processing decode on Funct[4:1]; CMP and unknown encodings never write Rd.
    always_comb begin
        aluOp      = 2'b00;
        aluNoWrite = 1'b0;
        aluArith   = 1'b0;
        aluIsCmp   = 1'b0;
        case (bus.Funct[4:1])
            4'b0100: begin
                aluOp    = 2'b00;
                aluArith = 1'b1;
            end
            4'b0010: begin
                aluOp    = 2'b01;
                aluArith = 1'b1;
            end
            4'b0000: begin
                aluOp    = 2'b10;
            end
            4'b1100: begin
                aluOp    = 2'b11;
            end
            4'b1010: begin
                aluOp      = 2'b01;
                aluArith   = 1'b1;
                aluIsCmp   = 1'b1;
                aluNoWrite = 1'b1;
            end
            default: begin
                aluOp      = 2'b00;
                aluNoWrite = 1'b1;
            end
        endcase
    end

    // State register and next-state sequencing; unused codes recover to FETCH.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            curState <= FETCH;
        end else begin
            case (curState)
                FETCH:    curState <= bus.MemReady ? DECODE : FETCH;
                DECODE: begin
                    case (bus.Op)
                        2'b00:   curState <= bus.Funct[5] ? EXECI : EXECR;
                        2'b01:   curState <= MEMADR;
                        2'b10:   curState <= BRANCH;
                        default: curState <= FETCH;
                    endcase
                end
                MEMADR:   curState <= bus.Funct[0] ? MEMREAD : MEMWRITE;
                MEMREAD:  curState <= bus.MemReady ? MEMWB : MEMREAD;
                MEMWB:    curState <= FETCH;
                MEMWRITE: curState <= bus.MemReady ? FETCH : MEMWRITE;
                EXECR:    curState <= ALUWB;
                EXECI:    curState <= ALUWB;
                ALUWB:    curState <= FETCH;
                BRANCH:   curState <= FETCH;
                default:  curState <= FETCH;
            endcase
        end
    end

    // NZCV register: loads on the execute edge of an executed flag-setting op;
    // logical ops leave C and V untouched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flagsReg <= 4'b0000;
        end else if (((curState == EXECR) || (curState == EXECI)) &&
                     condEx && (bus.Funct[0] || aluIsCmp)) begin
            flagsReg[3:2] <= bus.ALUFlags[3:2];
            if (aluArith) begin
                flagsReg[1:0] <= bus.ALUFlags[1:0];
            end else begin
                flagsReg[1:0] <= flagsReg[1:0];
            end
        end else begin
            flagsReg <= flagsReg;
        end
    end

    // ALU result write-back is suppressed for CMP and unknown encodings.
    always_comb begin
        aluWbWrite = condEx & ~aluNoWrite;
    end

    // Per-state datapath controls; anything not set for a state stays 0 / ADD.
    always_comb begin
        pcWriteRaw  = 1'b0;
        irWriteRaw  = 1'b0;
        memWriteRaw = 1'b0;
        regWriteRaw = 1'b0;
        adrSrc      = 1'b0;
        aluSrcA     = 1'b0;
        aluSrcB     = 2'b00;
        resultSrc   = 2'b00;
        aluControl  = 2'b00;
        case (curState)
            FETCH: begin
                aluSrcA    = 1'b1;
                aluSrcB    = 2'b10;
                resultSrc  = 2'b10;
                pcWriteRaw = bus.MemReady;
                irWriteRaw = bus.MemReady;
            end
            DECODE: begin
                aluSrcA   = 1'b1;
                aluSrcB   = 2'b10;
                resultSrc = 2'b10;
            end
            MEMADR: begin
                aluSrcB = 2'b01;
            end
            MEMREAD: begin
                adrSrc = 1'b1;
            end
            MEMWB: begin
                resultSrc   = 2'b01;
                regWriteRaw = condEx;
            end
            MEMWRITE: begin
                adrSrc      = 1'b1;
                memWriteRaw = condEx;
            end
            EXECR: begin
                aluSrcB    = 2'b00;
                aluControl = aluOp;
            end
            EXECI: begin
                aluSrcB    = 2'b01;
                aluControl = aluOp;
            end
            ALUWB: begin
                resultSrc   = 2'b00;
                regWriteRaw = aluWbWrite;
                pcWriteRaw  = aluWbWrite & (bus.Rd == 4'b1111);
            end
            BRANCH: begin
                aluSrcB    = 2'b01;
                resultSrc  = 2'b10;
                pcWriteRaw = condEx;
            end
            default: begin
                pcWriteRaw = 1'b0;
            end
        endcase
    end

    // Write enables are forced low for as long as reset is held.
    assign bus.PCWrite    = pcWriteRaw  & reset_n;
    assign bus.IRWrite    = irWriteRaw  & reset_n;
    assign bus.MemWrite   = memWriteRaw & reset_n;
    assign bus.RegWrite   = regWriteRaw & reset_n;
    assign bus.AdrSrc     = adrSrc;
    assign bus.ALUSrcA    = aluSrcA;
    assign bus.ALUSrcB    = aluSrcB;
    assign bus.ResultSrc  = resultSrc;
    assign bus.ALUControl = aluControl;
    assign bus.ImmSrc     = bus.Op;
    assign bus.RegSrc     = {(bus.Op == 2'b01), (bus.Op == 2'b10)};
    assign bus.Flags      = flagsReg;
    assign bus.State      = curState;

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
// Instruction-level reference model: for each instruction the bench builds the
// expected per-cycle control trace (plus the MemReady pattern to drive), runs
// the controller for that many cycles and compares every sampled cycle.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

    logic clk;
    logic reset_n;

    multicycle_controller_if busIf();

    multicycle_controller dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (busIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] state;
        logic       pcw;
        logic       irw;
        logic       mw;
        logic       rw;
        logic       adrSrc;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] resultSrc;
        logic [1:0] aluCtl;
        logic [1:0] immSrc;
        logic [1:0] regSrc;
        logic [3:0] flags;
    } cycRec;

    cycRec      expQ[$];
    cycRec      obsQ[$];
    logic       stimQ[$];
    logic [3:0] mFlags;
    int         nChecks;
    int         nFails;

    // ARM condition table: pairs of codes share a base test, odd code inverts it.
    function automatic logic holds(input logic [3:0] cond, input logic [3:0] f);
        logic base;
        if (cond == 4'b1111) return 1'b0;
        if (cond == 4'b1110) return 1'b1;
        case (cond[3:1])
            3'd0:    base = f[2];
            3'd1:    base = f[1];
            3'd2:    base = f[3];
            3'd3:    base = f[0];
            3'd4:    base = f[1] && !f[2];
            3'd5:    base = (f[3] == f[0]);
            3'd6:    base = !f[2] && (f[3] == f[0]);
            default: base = 1'b0;
        endcase
        return base ^ cond[0];
    endfunction

    // Build the expected trace of one instruction and advance the flag model.
    task automatic modelInstr(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] rd,
                              input logic [3:0] cond, input logic [3:0] af,
                              input int fetchWait, input int memWait);
        cycRec b;
        cycRec r;
        logic [3:0] kind;
        logic isCmp;
        logic writes;
        logic arith;
        logic [1:0] ctl;
        expQ.delete();
        stimQ.delete();
        kind = fn[4:1];
        b = '0;
        b.immSrc = op;
        b.regSrc = {op == 2'b01, op == 2'b10};
        b.flags  = mFlags;
        for (int i = 0; i <= fetchWait; i++) begin
            r = b; r.aluSrcA = 1'b1; r.aluSrcB = 2'd2; r.resultSrc = 2'd2;
            r.pcw = (i == fetchWait); r.irw = (i == fetchWait);
            expQ.push_back(r); stimQ.push_back(i == fetchWait);
        end
        r = b; r.state = 4'd1; r.aluSrcA = 1'b1; r.aluSrcB = 2'd2; r.resultSrc = 2'd2;
        expQ.push_back(r); stimQ.push_back(1'($urandom_range(0, 1)));
        if (op == 2'b01) begin
            r = b; r.state = 4'd2; r.aluSrcB = 2'd1;
            expQ.push_back(r); stimQ.push_back(1'($urandom_range(0, 1)));
            for (int i = 0; i <= memWait; i++) begin
                r = b; r.state = fn[0] ? 4'd3 : 4'd5; r.adrSrc = 1'b1;
                r.mw = !fn[0] && holds(cond, mFlags);
                expQ.push_back(r); stimQ.push_back(i == memWait);
            end
            if (fn[0]) begin
                r = b; r.state = 4'd4; r.resultSrc = 2'd1; r.rw = holds(cond, mFlags);
                expQ.push_back(r); stimQ.push_back(1'($urandom_range(0, 1)));
            end
        end else if (op == 2'b00) begin
            isCmp  = (kind == 4'b1010);
            writes = kind inside {4'b0100, 4'b0010, 4'b0000, 4'b1100};
            arith  = kind inside {4'b0100, 4'b0010, 4'b1010};
            ctl    = (kind == 4'b0010 || isCmp) ? 2'd1 :
                     (kind == 4'b0000) ? 2'd2 : (kind == 4'b1100) ? 2'd3 : 2'd0;
            r = b; r.state = fn[5] ? 4'd7 : 4'd6; r.aluSrcB = fn[5] ? 2'd1 : 2'd0; r.aluCtl = ctl;
            expQ.push_back(r); stimQ.push_back(1'($urandom_range(0, 1)));
            if (holds(cond, mFlags) && (fn[0] || isCmp)) begin
                mFlags[3:2] = af[3:2];
                if (arith) mFlags[1:0] = af[1:0];
            end
            r = b; r.flags = mFlags; r.state = 4'd8;
            r.rw  = holds(cond, mFlags) && writes;
            r.pcw = r.rw && (rd == 4'd15);
            expQ.push_back(r); stimQ.push_back(1'($urandom_range(0, 1)));
        end else if (op == 2'b10) begin
            r = b; r.state = 4'd9; r.aluSrcB = 2'd1; r.resultSrc = 2'd2; r.pcw = holds(cond, mFlags);
            expQ.push_back(r); stimQ.push_back(1'($urandom_range(0, 1)));
        end
    endtask

    function automatic cycRec sampleOut();
        cycRec s;
        s.state = busIf.State;         s.pcw = busIf.PCWrite;      s.irw = busIf.IRWrite;
        s.mw = busIf.MemWrite;         s.rw = busIf.RegWrite;      s.adrSrc = busIf.AdrSrc;
        s.aluSrcA = busIf.ALUSrcA;     s.aluSrcB = busIf.ALUSrcB;  s.resultSrc = busIf.ResultSrc;
        s.aluCtl = busIf.ALUControl;   s.immSrc = busIf.ImmSrc;    s.regSrc = busIf.RegSrc;
        s.flags = busIf.Flags;
        return s;
    endfunction

    // Run one instruction for exactly as many cycles as the model trace; entered at posedge+1.
    task automatic execInstr(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] rd,
                             input logic [3:0] cond, input logic [3:0] af);
        obsQ.delete();
        busIf.Op = op; busIf.Funct = fn; busIf.Rd = rd; busIf.Cond = cond; busIf.ALUFlags = af;
        foreach (stimQ[i]) begin
            busIf.MemReady = stimQ[i];
            @(negedge clk);
            obsQ.push_back(sampleOut());
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        busIf.Op = 2'b00; busIf.Funct = 6'd0; busIf.Rd = 4'd0; busIf.Cond = 4'b1110;
        busIf.ALUFlags = 4'd0; busIf.MemReady = 1'b1;
        #3;
        nChecks++;
        if (busIf.State !== 4'd0 || busIf.Flags !== 4'd0 || busIf.MemWrite !== 1'b0 || busIf.RegWrite !== 1'b0) begin
            nFails++;
            $display("FAIL reset_async: state=%0d flags=%b mw=%b rw=%b, expected 0 0000 0 0",
                     busIf.State, busIf.Flags, busIf.MemWrite, busIf.RegWrite);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        nChecks++;
        if (busIf.State !== 4'd0 || busIf.Flags !== 4'd0) begin
            nFails++;
            $display("FAIL reset_clocked: state=%0d flags=%b, expected 0 0000", busIf.State, busIf.Flags);
        end
        busIf.MemReady = 1'b0;
        reset_n = 1'b1;
        mFlags = 4'd0;
        #1;
        nChecks++;
        if (busIf.State !== 4'd0) begin
            nFails++;
            $display("FAIL reset_release: state=%0d, expected 0", busIf.State);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_str_condfail();
        modelInstr(2'b01, 6'b011000, 4'd3, 4'b0000, 4'($urandom), 0, 2);
        execInstr(2'b01, 6'b011000, 4'd3, 4'b0000, 4'($urandom));
        foreach (expQ[i]) begin
            nChecks++;
            if (obsQ[i] !== expQ[i]) begin
                nFails++;
                $display("FAIL str_condfail cycle %0d: got %h, expected %h", i, obsQ[i], expQ[i]);
            end
        end
        nChecks++;
        if (obsQ[3].state !== 4'd5 || obsQ[3].mw !== 1'b0 || busIf.State !== 4'd0) begin
            nFails++;
            $display("FAIL str_condfail_spot: memwrite state=%0d mw=%b final=%0d, expected 5 0 0",
                     obsQ[3].state, obsQ[3].mw, busIf.State);
        end
    endtask

    task automatic test_add();
        logic [3:0] want [4];
        want[0] = 4'd0; want[1] = 4'd1; want[2] = 4'd6; want[3] = 4'd8;
        modelInstr(2'b00, 6'b001000, 4'd1, 4'b1110, 4'b1111, 0, 0);
        execInstr(2'b00, 6'b001000, 4'd1, 4'b1110, 4'b1111);
        foreach (expQ[i]) begin
            nChecks++;
            if (obsQ[i] !== expQ[i]) begin
                nFails++;
                $display("FAIL add cycle %0d: got %h, expected %h", i, obsQ[i], expQ[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            nChecks++;
            if (obsQ[i].state !== want[i] || obsQ[i].rw !== (i == 3)) begin
                nFails++;
                $display("FAIL add_spot[%0d]: state=%0d rw=%b, expected %0d %b", i, obsQ[i].state, obsQ[i].rw, want[i], i == 3);
            end
        end
        nChecks++;
        if (obsQ[2].aluCtl !== 2'b00) begin
            nFails++;
            $display("FAIL add_aluctl: got %b, expected 00", obsQ[2].aluCtl);
        end
    endtask

    task automatic test_ldr_wait();
        modelInstr(2'b01, 6'b011001, 4'd2, 4'b1110, 4'd0, 0, 3);
        execInstr(2'b01, 6'b011001, 4'd2, 4'b1110, 4'd0);
        foreach (expQ[i]) begin
            nChecks++;
            if (obsQ[i] !== expQ[i]) begin
                nFails++;
                $display("FAIL ldr cycle %0d: got %h, expected %h", i, obsQ[i], expQ[i]);
            end
        end
        for (int i = 3; i <= 6; i++) begin
            nChecks++;
            if (obsQ[i].state !== 4'd3) begin
                nFails++;
                $display("FAIL ldr_hold[%0d]: state=%0d, expected 3", i, obsQ[i].state);
            end
        end
        nChecks++;
        if (obsQ[7].state !== 4'd4 || obsQ[7].resultSrc !== 2'b01 || obsQ[7].rw !== 1'b1) begin
            nFails++;
            $display("FAIL ldr_memwb: state=%0d rs=%b rw=%b, expected 4 01 1", obsQ[7].state, obsQ[7].resultSrc, obsQ[7].rw);
        end
    endtask

    task automatic test_cmp_branch();
        logic [3:0] conds [2];
        conds[0] = 4'b0000; conds[1] = 4'b0001;
        modelInstr(2'b00, 6'b010101, 4'd0, 4'b1110, 4'b0100, 0, 0);
        execInstr(2'b00, 6'b010101, 4'd0, 4'b1110, 4'b0100);
        foreach (expQ[i]) begin
            nChecks++;
            if (obsQ[i] !== expQ[i]) begin
                nFails++;
                $display("FAIL cmp cycle %0d: got %h, expected %h", i, obsQ[i], expQ[i]);
            end
        end
        nChecks++;
        if (busIf.Flags !== 4'b0100) begin
            nFails++;
            $display("FAIL cmp_flags: got %b, expected 0100", busIf.Flags);
        end
        for (int k = 0; k < 2; k++) begin
            modelInstr(2'b10, 6'b100000, 4'd0, conds[k], 4'd0, 1, 0);
            execInstr(2'b10, 6'b100000, 4'd0, conds[k], 4'd0);
            foreach (expQ[i]) begin
                nChecks++;
                if (obsQ[i] !== expQ[i]) begin
                    nFails++;
                    $display("FAIL branch%0d cycle %0d: got %h, expected %h", k, i, obsQ[i], expQ[i]);
                end
            end
            nChecks++;
            if (obsQ[3].state !== 4'd9 || obsQ[3].pcw !== (k == 0)) begin
                nFails++;
                $display("FAIL branch%0d_pcw: state=%0d pcw=%b, expected 9 %b", k, obsQ[3].state, obsQ[3].pcw, k == 0);
            end
        end
    endtask

    task automatic test_op11();
        modelInstr(2'b11, 6'b111111, 4'd15, 4'b1110, 4'd0, 0, 0);
        execInstr(2'b11, 6'b111111, 4'd15, 4'b1110, 4'd0);
        foreach (expQ[i]) begin
            nChecks++;
            if (obsQ[i] !== expQ[i]) begin
                nFails++;
                $display("FAIL op11 cycle %0d: got %h, expected %h", i, obsQ[i], expQ[i]);
            end
        end
        busIf.MemReady = 1'b0;
        #1;
        nChecks++;
        if (busIf.State !== 4'd0 || {busIf.PCWrite, busIf.IRWrite, busIf.MemWrite, busIf.RegWrite} !== 4'b0000 ||
            {obsQ[1].pcw, obsQ[1].irw, obsQ[1].mw, obsQ[1].rw} !== 4'b0000) begin
            nFails++;
            $display("FAIL op11_noside: state=%0d enables=%b decode_en=%b, expected 0 0000 0000", busIf.State,
                     {busIf.PCWrite, busIf.IRWrite, busIf.MemWrite, busIf.RegWrite},
                     {obsQ[1].pcw, obsQ[1].irw, obsQ[1].mw, obsQ[1].rw});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [1:0] op;
        logic [5:0] fn;
        logic [3:0] rd;
        logic [3:0] cond;
        logic [3:0] af;
        logic [3:0] kind;
        int         sel;
        for (int n = 0; n < 60; n++) begin
            op   = 2'($urandom);
            fn   = 6'($urandom);
            rd   = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
            cond = ($urandom_range(0, 2) == 0) ? 4'b1110 : 4'($urandom);
            af   = 4'($urandom);
            if (op == 2'b00) begin
                sel = $urandom_range(0, 5);
                case (sel)
                    0: kind = 4'b0100;
                    1: kind = 4'b0010;
                    2: kind = 4'b0000;
                    3: kind = 4'b1100;
                    4: kind = 4'b1010;
                    default: kind = 4'($urandom);
                endcase
                fn[4:1] = kind;
                if (sel == 5) fn[0] = 1'b0;
            end
            modelInstr(op, fn, rd, cond, af, $urandom_range(0, 2), $urandom_range(0, 3));
            execInstr(op, fn, rd, cond, af);
            foreach (expQ[i]) begin
                nChecks++;
                if (obsQ[i] !== expQ[i]) begin
                    nFails++;
                    $display("FAIL random%0d op=%b fn=%b cond=%b cycle %0d: got %h, expected %h",
                             n, op, fn, cond, i, obsQ[i], expQ[i]);
                end
            end
        end
    endtask

    task automatic test_reset_midwrite();
        modelInstr(2'b00, 6'b010101, 4'd0, 4'b1110, 4'b1111, 0, 0);
        execInstr(2'b00, 6'b010101, 4'd0, 4'b1110, 4'b1111);
        busIf.Op = 2'b01; busIf.Funct = 6'b011000; busIf.Cond = 4'b1110;
        busIf.MemReady = 1'b1;
        @(posedge clk); #1;
        busIf.MemReady = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        nChecks++;
        if (busIf.State !== 4'd5 || busIf.MemWrite !== 1'b1 || busIf.Flags !== 4'b1111) begin
            nFails++;
            $display("FAIL midwrite_pre: state=%0d mw=%b flags=%b, expected 5 1 1111", busIf.State, busIf.MemWrite, busIf.Flags);
        end
        #2;
        reset_n = 1'b0;
        #1;
        nChecks++;
        if (busIf.State !== 4'd0 || busIf.MemWrite !== 1'b0 || busIf.RegWrite !== 1'b0 || busIf.Flags !== 4'd0) begin
            nFails++;
            $display("FAIL midwrite_abort: state=%0d mw=%b rw=%b flags=%b, expected 0 0 0 0000",
                     busIf.State, busIf.MemWrite, busIf.RegWrite, busIf.Flags);
        end
        #2;
        reset_n = 1'b1;
        mFlags = 4'd0;
        @(posedge clk); #1;
        nChecks++;
        if (busIf.State !== 4'd0) begin
            nFails++;
            $display("FAIL midwrite_restart: state=%0d, expected 0", busIf.State);
        end
    endtask

    initial begin
        nChecks = 0;
        nFails  = 0;
        mFlags  = 4'd0;
        test_reset();
        test_str_condfail();
        test_add();
        test_ldr_wait();
        test_cmp_branch();
        test_op11();
        test_random();
        test_reset_midwrite();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-low reset; all other ports SHALL be as listed in REQ-002..REQ-011.
REQ-002 clk  in  1  single clock, rising-edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 Op, Funct, Rd, Cond  in  2/6/4/4  fields of the latched instruction register.
REQ-005 ALUFlags  in  4  NZCV from the ALU, current cycle.
REQ-006 MemReady  in  1  memory handshake; access completes on a cycle where it is 1.
REQ-007 PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA  out  1  datapath enables and selects.
REQ-008 ALUSrcB, ResultSrc, ImmSrc, RegSrc  out  2 each  datapath selects.
REQ-009 ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR.
REQ-010 Flags  out  4  architectural NZCV register.
REQ-011 State  out  4  current FSM state encoding, for debug.

Function
REQ-012 The states SHALL be encoded FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9; codes 10-15 SHALL go to FETCH on the next edge.
REQ-013 FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALU ADD; with MemReady=1, IRWrite=1, PCWrite=1 and the next state is DECODE; otherwise both are 0 and the FSM stays in FETCH.
REQ-014 DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10. Next state: Op=01 -> MEMADR; Op=00 with Funct[5]=0 -> EXECR; Op=00 with Funct[5]=1 -> EXECI; Op=10 -> BRANCH; Op=11 -> FETCH with no side effects.
REQ-015 MEMADR: ALUSrcA=0, ALUSrcB=01, ADD. Next state: Funct[0]=1 -> MEMREAD; Funct[0]=0 -> MEMWRITE.
REQ-016 MEMREAD: AdrSrc=1. It holds until MemReady=1, then goes to MEMWB.
REQ-017 MEMWB: ResultSrc=01, RegWrite=CondEx, then FETCH.
REQ-018 MEMWRITE: AdrSrc=1, MemWrite=CondEx, held stable while MemReady=0; with MemReady=1 the next state is FETCH.
REQ-019 EXECR and EXECI: ALUSrcA=0, ALUSrcB=00 (EXECR) or 01 (EXECI), ALUControl from REQ-022, then ALUWB.
REQ-020 ALUWB: ResultSrc=00, RegWrite=CondEx and not CMP; with Rd=1111 and the write enabled, PCWrite=1 also; then FETCH.
REQ-021 BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, ADD, PCWrite=CondEx, then FETCH.
REQ-022 ALU decode (EXECR/EXECI only), on Funct[4:1]:
  - 0100 ADD
  - 0010 SUB
  - 0000 AND
  - 1100 ORR
  - 1010 CMP (SUB, no register write)
  - any other value: ADD with RegWrite suppressed.
  In all other states ALUControl SHALL be ADD.
REQ-023 Flag update: at the EXECR/EXECI edge, if CondEx and Funct[0]=1 (or CMP), N,Z SHALL load from ALUFlags; C,V SHALL load only for ADD/SUB/CMP. Flags SHALL otherwise hold.
REQ-024 CondEx SHALL be evaluated against the Flags register using ARM codes 0000-1110 (EQ..AL); Cond=1111 SHALL give CondEx=0.
REQ-025 ImmSrc SHALL equal Op. RegSrc[0] SHALL be 1 for Op=10; RegSrc[1] SHALL be 1 for Op=01.
REQ-026 All outputs SHALL be combinational in State, the inputs and Flags; state and Flags SHALL change only on a rising clk edge or on reset.
REQ-027 Any enable not listed for a state SHALL be 0 in that state.

Reset
REQ-028 While reset_n=0, State SHALL be FETCH, Flags SHALL be 0000, and MemWrite and RegWrite SHALL be 0, independent of clk.
REQ-029 An assertion of reset_n in the middle of an instruction SHALL abort it immediately with no further write enables.
REQ-030 After reset_n deasserts, the first state SHALL be FETCH.

Verification
REQ-031 ADD R1 (Op=00, Funct=001000, Cond=1110), MemReady=1 -> FETCH, DECODE, EXECR, ALUWB; RegWrite=1 only in ALUWB; ALUControl=00; 4 cycles.
REQ-032 LDR (Op=01, Funct=011001), MemReady=0 for 3 cycles in MEMREAD -> State stays 3 for those cycles, then MEMWB with ResultSrc=01, RegWrite=1.
REQ-033 CMP with S (Funct=010101) and ALUFlags=0100, then BEQ (Op=10, Cond=0000) -> Flags=0100; PCWrite=1 in BRANCH. With Cond=0001 -> PCWrite=0.
REQ-034 STR with Cond=0000 and Flags=0000 -> MemWrite=0 in MEMWRITE; the FSM still returns to FETCH.
REQ-035 reset_n pulsed low during MEMWRITE with MemReady=0 -> MemWrite drops to 0 asynchronously; State=0 and Flags=0000 before the next edge.
REQ-036 Op=11 -> FETCH, DECODE, FETCH with no write enables asserted.
